// File: rtl/nibble_bus_arbiter_pkg.sv
// Shared types and constants for the nibble bus arbiter.
package nibble_bus_arbiter_pkg;

    // Arbiter ownership states, one-hot encoded.
    typedef enum logic [2:0] {
        ST_FREE = 3'b001,
        ST_OWN0 = 3'b010,
        ST_OWN1 = 3'b100
    } arb_state_e;

    // Requester indices.
    localparam int unsigned PORT_CPU = 0;
    localparam int unsigned PORT_DBG = 1;

    // Default bus geometry.
    localparam int unsigned AW_DEFAULT = 12;
    localparam int unsigned DW_DEFAULT = 4;

    // Pad mapping: address[7:0] on the dedicated outputs, address[11:8] on
    // bidir[7:4], data on bidir[3:0]; the write strobe enables the data pins.
    localparam int unsigned DED_ADDR_W        = 8;
    localparam int unsigned BIDIR_DATA_LSB    = 0;
    localparam int unsigned BIDIR_ADDR_HI_LSB = 4;
    localparam int unsigned BUS_CTL_WE_BIT    = 0;

endpackage

// File: rtl/nibble_bus_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker with an owner-hold override.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       force_last,
    output logic [1:0] win
);

    // When forced, only the last winner (the current owner) may win;
    // otherwise a contended pick goes to the port that did not win last.
    always_comb begin
        win = '0;
        if (force_last) begin
            win[last] = req[last];
        end else if (req == 2'b11) begin
            win = last ? 2'b01 : 2'b10;
        end else begin
            win = req;
        end
    end

endmodule

// File: rtl/nibble_bus_arbiter.sv
// Two-port arbiter for the external nibble bus: round-robin with a bounded
// ownership lock, registered bus outputs and a one-cycle read return.
module nibble_bus_arbiter
    import nibble_bus_arbiter_pkg::*;
#(
    parameter int unsigned AW       = AW_DEFAULT,
    parameter int unsigned DW       = DW_DEFAULT,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_i,
    input  logic [1:0]           lock_i,
    input  logic [1:0]           we_i,
    input  logic [1:0][AW-1:0]   addr_i,
    input  logic [1:0][DW-1:0]   wdata_i,
    output logic [1:0]           gnt_o,
    output logic [1:0]           rvalid_o,
    output logic [DW-1:0]        rdata_o,
    output logic [AW-1:0]        bus_addr_o,
    output logic                 bus_we_o,
    output logic [DW-1:0]        bus_wdata_o,
    input  logic [DW-1:0]        bus_rdata_i
);

    localparam int unsigned    CW      = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_LOCK);

    arb_state_e     state_q, state_d;
    logic           rr_last_q, rr_last_d;
    logic [CW-1:0]  lock_cnt_q, lock_cnt_d;
    logic [CW-1:0]  cnt_next;
    logic [AW-1:0]  bus_addr_q, bus_addr_d;
    logic           bus_we_q, bus_we_d;
    logic [DW-1:0]  bus_wdata_q, bus_wdata_d;
    logic [1:0]     rd_pend_q, rd_pend_d;
    logic [1:0]     rvalid_q, rvalid_d;
    logic [DW-1:0]  rdata_q, rdata_d;

    logic [1:0]     win;
    logic           owned;
    logic           xfer;
    logic           wp;

    assign owned = (state_q != ST_FREE);
    assign xfer  = |win;
    assign wp    = win[PORT_DBG];

    // While owned, rr_last always equals the owner, so forcing the picker
    // onto rr_last restricts grants to the owner without a separate index.
    rr_pick2 u_pick (
        .req        (req_i),
        .last       (rr_last_q),
        .force_last (owned),
        .win        (win)
    );

    // Grant is combinational, suppressed during reset.
    always_comb begin
        gnt_o = rst ? '0 : win;
    end

    // Ownership state, lock counter and round-robin pointer.
    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        lock_cnt_d = lock_cnt_q;
        cnt_next   = owned ? (lock_cnt_q + 1'b1) : CW'(1);
        if (xfer) begin
            rr_last_d = wp;
            if (lock_i[wp] && (cnt_next != CNT_MAX)) begin
                state_d    = wp ? ST_OWN1 : ST_OWN0;
                lock_cnt_d = cnt_next;
            end else begin
                state_d    = ST_FREE;
                lock_cnt_d = '0;
            end
        end else if (owned) begin
            // Owner dropped its request: release without granting.
            state_d    = ST_FREE;
            lock_cnt_d = '0;
        end
    end

    // Bus launch and read-return pipeline.
    always_comb begin
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_we_d    = 1'b0;
        rd_pend_d   = '0;
        if (xfer) begin
            bus_addr_d  = addr_i[wp];
            bus_we_d    = we_i[wp];
            bus_wdata_d = wdata_i[wp];
            rd_pend_d   = win & ~{2{we_i[wp]}};
        end
        rvalid_d = rd_pend_q;
        rdata_d  = (|rd_pend_q) ? bus_rdata_i : rdata_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FREE;
            rr_last_q   <= 1'b1;
            lock_cnt_q  <= '0;
            bus_addr_q  <= '0;
            bus_we_q    <= 1'b0;
            bus_wdata_q <= '0;
            rd_pend_q   <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            lock_cnt_q  <= lock_cnt_d;
            bus_addr_q  <= bus_addr_d;
            bus_we_q    <= bus_we_d;
            bus_wdata_q <= bus_wdata_d;
            rd_pend_q   <= rd_pend_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus_addr_o  = bus_addr_q;
    assign bus_we_o    = bus_we_q;
    assign bus_wdata_o = bus_wdata_q;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_nibble_bus_arbiter.sv
// Directed self-checking bench for nibble_bus_arbiter.
module tb_nibble_bus_arbiter;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_i, lock_i, we_i;
    logic [1:0][11:0]  addr_i;
    logic [1:0][3:0]   wdata_i;
    logic [1:0]        gnt_o, rvalid_o;
    logic [3:0]        rdata_o;
    logic [11:0]       bus_addr_o;
    logic              bus_we_o;
    logic [3:0]        bus_wdata_o;
    logic [3:0]        bus_rdata_i;

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;

    always #5 clk = ~clk;

    nibble_bus_arbiter #(
        .AW       (12),
        .DW       (4),
        .MAX_LOCK (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .lock_i      (lock_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .bus_addr_o  (bus_addr_o),
        .bus_we_o    (bus_we_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_rdata_i (bus_rdata_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        req_i   = '0;
        lock_i  = '0;
        we_i    = '0;
        addr_i  = '0;
        wdata_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0]  alt_gnt [4];
        logic [11:0] alt_addr [4];
        alt_gnt  = '{2'b01, 2'b10, 2'b01, 2'b10};
        alt_addr = '{12'h000, 12'h100, 12'h200, 12'h100};

        rst = 1'b1;
        idle_inputs();
        bus_rdata_i = 4'h0;

        // Basic read; grant must be masked while in reset.
        tick();
        req_i = 2'b01; addr_i[0] = 12'h123;
        settle();
        check("gnt_in_rst", gnt_o, 2'b00);
        tick();
        rst = 1'b0; bus_rdata_i = 4'hA;
        settle();
        check("rd_c0_gnt", gnt_o, 2'b01);
        check("rst_bus_addr", bus_addr_o, 12'h000);
        check("rst_bus_we", bus_we_o, 1'b0);
        check("rst_bus_wdata", bus_wdata_o, 4'h0);
        check("rst_rvalid", rvalid_o, 2'b00);
        check("rst_rdata", rdata_o, 4'h0);
        tick();
        req_i = 2'b00;
        settle();
        check("rd_c1_addr", bus_addr_o, 12'h123);
        check("rd_c1_we", bus_we_o, 1'b0);
        check("rd_c1_rvalid", rvalid_o, 2'b00);
        tick();
        settle();
        check("rd_c2_rvalid", rvalid_o, 2'b01);
        check("rd_c2_rdata", rdata_o, 4'hA);
        tick();
        settle();
        check("rd_c3_rvalid", rvalid_o, 2'b00);

        // Round-robin alternation, port 0 first after reset.
        do_reset();
        req_i = 2'b11; addr_i[0] = 12'h100; addr_i[1] = 12'h200;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("rr_gnt%0d", i), gnt_o, alt_gnt[i]);
            if (i > 0) check($sformatf("rr_addr%0d", i), bus_addr_o, alt_addr[i]);
            tick();
        end

        // Locked three-nibble fetch on port 0 against a persistent port 1.
        do_reset();
        bus_rdata_i = 4'h3;
        req_i = 2'b11; lock_i = 2'b01; addr_i[0] = 12'h010; addr_i[1] = 12'h300;
        settle();
        check("lk_c0_gnt", gnt_o, 2'b01);
        tick();
        addr_i[0] = 12'h011;
        settle();
        check("lk_c1_gnt", gnt_o, 2'b01);
        check("lk_c1_addr", bus_addr_o, 12'h010);
        tick();
        addr_i[0] = 12'h012; lock_i = 2'b00;
        settle();
        check("lk_c2_gnt", gnt_o, 2'b01);
        check("lk_c2_addr", bus_addr_o, 12'h011);
        check("lk_c2_rvalid", rvalid_o, 2'b01);
        tick();
        req_i = 2'b10;
        settle();
        check("lk_c3_gnt", gnt_o, 2'b10);
        check("lk_c3_addr", bus_addr_o, 12'h012);
        check("lk_c3_rdata", rdata_o, 4'h3);
        tick();
        req_i = 2'b00;
        settle();
        check("lk_c4_addr", bus_addr_o, 12'h300);
        check("lk_c4_rvalid", rvalid_o, 2'b01);
        tick();
        settle();
        check("lk_c5_rvalid", rvalid_o, 2'b10);

        // Owner drops its request: no grant that cycle, then release.
        do_reset();
        req_i = 2'b11; lock_i = 2'b01;
        settle();
        check("drop_c0_gnt", gnt_o, 2'b01);
        tick();
        req_i = 2'b10;
        settle();
        check("drop_c1_gnt", gnt_o, 2'b00);
        tick();
        settle();
        check("drop_c2_gnt", gnt_o, 2'b10);
        tick();

        // Lock bound: 8 grants to port 0, one to port 1, then port 0 relocks.
        do_reset();
        req_i = 2'b11; lock_i = 2'b01;
        for (int i = 0; i < 10; i++) begin
            settle();
            check($sformatf("max_gnt%0d", i), gnt_o, (i == 8) ? 2'b10 : 2'b01);
            tick();
        end

        // Port 1 write: single-cycle strobe, no read return.
        do_reset();
        req_i = 2'b10; we_i = 2'b10; addr_i[1] = 12'hFFF; wdata_i[1] = 4'h5;
        settle();
        check("wr_c0_gnt", gnt_o, 2'b10);
        tick();
        idle_inputs();
        settle();
        check("wr_c1_we", bus_we_o, 1'b1);
        check("wr_c1_wdata", bus_wdata_o, 4'h5);
        check("wr_c1_addr", bus_addr_o, 12'hFFF);
        check("wr_c1_rvalid", rvalid_o, 2'b00);
        tick();
        settle();
        check("wr_c2_we", bus_we_o, 1'b0);
        check("wr_c2_addr_hold", bus_addr_o, 12'hFFF);
        check("wr_c2_rvalid", rvalid_o, 2'b00);
        tick();

        // Reset right after a read grant drops the pending return.
        req_i = 2'b01; addr_i[0] = 12'h0AB; bus_rdata_i = 4'hC;
        settle();
        check("mr_c0_gnt", gnt_o, 2'b01);
        check("mr_c0_rvalid", rvalid_o, 2'b00);
        tick();
        rst = 1'b1;
        settle();
        check("mr_c1_gnt_rst", gnt_o, 2'b00);
        check("mr_c1_addr", bus_addr_o, 12'h0AB);
        tick();
        rst = 1'b0; req_i = 2'b00;
        settle();
        check("mr_c2_addr", bus_addr_o, 12'h000);
        check("mr_c2_we", bus_we_o, 1'b0);
        check("mr_c2_wdata", bus_wdata_o, 4'h0);
        check("mr_c2_rvalid", rvalid_o, 2'b00);
        check("mr_c2_rdata", rdata_o, 4'h0);
        check("mr_c2_gnt", gnt_o, 2'b00);
        tick();
        settle();
        check("mr_c3_rvalid", rvalid_o, 2'b00);
        check("mr_c3_rdata", rdata_o, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
